vga_viewport_scaler: RTL and testbench
======================================

# vga_viewport_scaler

Maps the display timing generator's pixel coordinates to a world-map address for the video/icon path. It adds four things to fixed screen-to-world scaling:

- a programmable, frame-synchronised pan offset, so the world can be scrolled;
- a per-axis wrap or clamp mode at the map edge;
- sub-tile pixel offsets for icon rendering;
- a registered valid/in-map qualifier.

It contains no dividers; all addressing comes from counters stepped by the pixel stream.

## Interface
Parameters:
- RATIO_COL, 6, screen pixels per world column (≥1)
- RATIO_ROW, 6, screen pixels per world row (≥1)
- WORLD_COLS, 128, world map width in tiles
- WORLD_ROWS, 128, world map height in tiles
- WORLD_COL_W, 7, width of world column; 2^WORLD_COL_W ≥ WORLD_COLS
- WORLD_ROW_W, 7, width of world row; 2^WORLD_ROW_W ≥ WORLD_ROWS
- PIX_W, 12, pixel coordinate width
- ACTIVE_COLS, 1024, active screen columns
- ACTIVE_ROWS, 768, active screen rows
- WRAP_MODE, 0, 1 = wrap at the map edge (torus); 0 = clamp (pixels outside the map are flagged, not addressed)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_row  in  PIX_W  current pixel row from the timing generator
- pixel_column  in  PIX_W  current pixel column from the timing generator
- video_on  in  1  active-video qualifier
- pan_col_in  in  WORLD_COL_W  requested world column at the screen's left edge (< WORLD_COLS)
- pan_row_in  in  WORLD_ROW_W  requested world row at the screen's top edge (< WORLD_ROWS)
- pan_load  in  1  one-cycle strobe; captures pan_*_in into the shadow registers
- pan_busy  out  1  a captured pan is waiting for the next frame start
- world_row  out  WORLD_ROW_W  world row for the pixel
- world_column  out  WORLD_COL_W  world column for the pixel
- sub_row  out  clog2(RATIO_ROW) (min 1)  pixel row offset inside the tile, 0..RATIO_ROW-1
- sub_col  out  clog2(RATIO_COL) (min 1)  pixel column offset inside the tile, 0..RATIO_COL-1
- vid_addr  out  WORLD_ROW_W+WORLD_COL_W  {world_row, world_column}
- out_valid  out  1  registered enable (see Operation)
- in_map  out  1  the pixel maps inside the world

## Operation
- **enable** = video_on && pixel_column < ACTIVE_COLS && pixel_row < ACTIVE_ROWS. When enable is low, all counters hold, and out_valid and in_map are 0.
- **line_start** = enable && pixel_column == 0.
- **frame_start** = line_start && pixel_row == 0.
- **At frame_start:**
  - If pan_busy, copy shadow → active pan and clear pan_busy.
  - Row counters restart: sub_row = 0, raw_row = the new active pan_row.
- **At a line_start that is not a frame_start:** sub_row increments. When it passes RATIO_ROW-1 it returns to 0 and raw_row advances.
- **At every line_start:** sub_col = 0, raw_col = active pan_col.
- **At other enabled pixels:** sub_col increments. When it passes RATIO_COL-1 it returns to 0 and raw_col advances.
- **Advance rule, wrap mode:** the next value after WORLD_COLS-1 (or WORLD_ROWS-1) is 0. in_map = out_valid.
- **Advance rule, clamp mode:**
  - Raw counters are one bit wider than the world width and saturate at WORLD_COLS / WORLD_ROWS.
  - in_map = out_valid && raw_col < WORLD_COLS && raw_row < WORLD_ROWS.
  - When in_map = 0, world_row, world_column and vid_addr output 0.
- **pan_load:**
  - Writes the shadow registers and sets pan_busy.
  - A second load while busy overwrites the shadow; pan_busy stays 1.
  - A pan_load in the same cycle as frame_start is captured into the shadow but applied at the following frame. The current frame uses the previous active pan.
- **Reset:** all outputs 0; active and shadow pan 0; pan_busy 0. Reset mid-frame stops all updates; output becomes correct again from the next line_start (columns and sub_row) and the next frame_start (rows).

## Timing
- All outputs are registered. Results for the pixel presented in cycle t appear in cycle t+1 (latency 1).
- out_valid(t+1) = enable(t).
- Throughput is one pixel per clock.
- pan_busy rises the cycle after pan_load. It falls the cycle after the frame_start that applies the pan.
- Input pixel coordinates must advance by one per enabled cycle. A row always begins with column 0.

## Test plan
- **Reset values:** assert reset for 2 cycles with stimulus toggling → every output 0 during reset and 1 cycle after release with enable low.
- **Default scaling:** defaults, pan 0, scan rows 0..11 × cols 0..1023:
  - pixel (0,5) → world (0,0), sub_col 5
  - pixel (0,6) → world (0,1)
  - pixel (6,0) → world_row 1
  - pixel (0,1023) → world_column 170 wraps to 42 in wrap mode; in clamp mode in_map 0 for col ≥ 768
- **Pan timing:** pan_load with col 10 / row 5 at pixel (300,40) → pan_busy 1; rest of frame unchanged; next frame pixel (0,0) → vid_addr {5,10}, pan_busy 0.
- **Clamp edge:** WRAP_MODE 0, pan_col 100, pixel column 167 → world_column 127, in_map 1; column 168 → in_map 0, vid_addr 0.
- **Wrap edge:** WRAP_MODE 1, same stimulus → column 168 gives world_column 0, in_map 1.
- **Simultaneous events and reset:**
  - pan_load coincident with frame_start → old pan used this frame; new pan applied next frame.
  - video_on low for 20 cycles mid-line → counters hold, out_valid 0.
  - reset mid-line → outputs 0, and addressing is correct from the next frame.

Source files
------------

// File: rtl/vga_viewport_scaler.sv
// Maps timing-generator pixel coordinates to a world-map tile address with frame-synchronised pan,
// wrap/clamp map edges and sub-tile offsets. Latency 1 cycle, one pixel per clock, no backpressure.
module vga_viewport_scaler #(
  parameter int RATIO_COL   = 6,
  parameter int RATIO_ROW   = 6,
  parameter int WORLD_COLS  = 128,
  parameter int WORLD_ROWS  = 128,
  parameter int WORLD_COL_W = 7,
  parameter int WORLD_ROW_W = 7,
  parameter int PIX_W       = 12,
  parameter int ACTIVE_COLS = 1024,
  parameter int ACTIVE_ROWS = 768,
  parameter int WRAP_MODE   = 0,
  localparam int SUBR_W     = (RATIO_ROW > 1) ? $clog2(RATIO_ROW) : 1,
  localparam int SUBC_W     = (RATIO_COL > 1) ? $clog2(RATIO_COL) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PIX_W-1:0]               pixel_row,
  input  logic [PIX_W-1:0]               pixel_column,
  input  logic                           video_on,
  input  logic [WORLD_COL_W-1:0]         pan_col_in,
  input  logic [WORLD_ROW_W-1:0]         pan_row_in,
  input  logic                           pan_load,
  output logic                           pan_busy,
  output logic [WORLD_ROW_W-1:0]         world_row,
  output logic [WORLD_COL_W-1:0]         world_column,
  output logic [SUBR_W-1:0]              sub_row,
  output logic [SUBC_W-1:0]              sub_col,
  output logic [WORLD_ROW_W+WORLD_COL_W-1:0] vid_addr,
  output logic                           out_valid,
  output logic                           in_map
);

  // Raw counters carry one spare bit so clamp mode can saturate at the map size.
  localparam int RC_W = WORLD_COL_W + 1;
  localparam int RR_W = WORLD_ROW_W + 1;
  localparam logic [RC_W-1:0]   COL_LIM   = RC_W'(WORLD_COLS);
  localparam logic [RR_W-1:0]   ROW_LIM   = RR_W'(WORLD_ROWS);
  localparam logic [RC_W-1:0]   COL_LAST  = RC_W'(WORLD_COLS - 1);
  localparam logic [RR_W-1:0]   ROW_LAST  = RR_W'(WORLD_ROWS - 1);
  localparam logic [SUBC_W-1:0] SUBC_LAST = SUBC_W'(RATIO_COL - 1);
  localparam logic [SUBR_W-1:0] SUBR_LAST = SUBR_W'(RATIO_ROW - 1);
  localparam logic [PIX_W-1:0]  ACT_COLS  = PIX_W'(ACTIVE_COLS);
  localparam logic [PIX_W-1:0]  ACT_ROWS  = PIX_W'(ACTIVE_ROWS);

  logic [SUBC_W-1:0]      r_sub_col, w_sub_col_nxt;
  logic [SUBR_W-1:0]      r_sub_row, w_sub_row_nxt;
  logic [RC_W-1:0]        r_raw_col, w_raw_col_nxt;
  logic [RR_W-1:0]        r_raw_row, w_raw_row_nxt;
  logic [WORLD_COL_W-1:0] r_pan_col, r_shd_col, w_pan_col_eff;
  logic [WORLD_ROW_W-1:0] r_pan_row, r_shd_row, w_pan_row_eff;
  logic                   r_pan_busy;
  logic                   r_out_valid, r_in_map;
  logic [WORLD_COL_W-1:0] r_world_col;
  logic [WORLD_ROW_W-1:0] r_world_row;
  logic                   w_enable, w_line_start, w_frame_start;
  logic                   w_in_map_nxt, w_show;

  function automatic logic [RC_W-1:0] adv_col(input logic [RC_W-1:0] v);
    if (WRAP_MODE != 0) return (v >= COL_LAST) ? '0 : v + 1'b1;
    else                return (v >= COL_LIM) ? COL_LIM : v + 1'b1;
  endfunction

  function automatic logic [RR_W-1:0] adv_row(input logic [RR_W-1:0] v);
    if (WRAP_MODE != 0) return (v >= ROW_LAST) ? '0 : v + 1'b1;
    else                return (v >= ROW_LIM) ? ROW_LIM : v + 1'b1;
  endfunction

  assign w_enable      = video_on && (pixel_column < ACT_COLS) && (pixel_row < ACT_ROWS);
  assign w_line_start  = w_enable && (pixel_column == '0);
  assign w_frame_start = w_line_start && (pixel_row == '0);

  // A pending shadow pan takes effect on the very frame_start that applies it.
  assign w_pan_col_eff = r_pan_busy ? r_shd_col : r_pan_col;
  assign w_pan_row_eff = r_pan_busy ? r_shd_row : r_pan_row;

  always_comb begin
    w_sub_col_nxt = r_sub_col;
    w_sub_row_nxt = r_sub_row;
    w_raw_col_nxt = r_raw_col;
    w_raw_row_nxt = r_raw_row;
    if (w_frame_start) begin
      w_sub_row_nxt = '0;
      w_raw_row_nxt = {1'b0, w_pan_row_eff};
    end else if (w_line_start) begin
      if (r_sub_row >= SUBR_LAST) begin
        w_sub_row_nxt = '0;
        w_raw_row_nxt = adv_row(r_raw_row);
      end else begin
        w_sub_row_nxt = r_sub_row + 1'b1;
      end
    end
    if (w_line_start) begin
      w_sub_col_nxt = '0;
      w_raw_col_nxt = {1'b0, (w_frame_start ? w_pan_col_eff : r_pan_col)};
    end else if (w_enable) begin
      if (r_sub_col >= SUBC_LAST) begin
        w_sub_col_nxt = '0;
        w_raw_col_nxt = adv_col(r_raw_col);
      end else begin
        w_sub_col_nxt = r_sub_col + 1'b1;
      end
    end
    w_in_map_nxt = w_enable && ((WRAP_MODE != 0) ||
                                ((w_raw_col_nxt < COL_LIM) && (w_raw_row_nxt < ROW_LIM)));
    w_show       = (WRAP_MODE != 0) || w_in_map_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sub_col   <= '0;
      r_sub_row   <= '0;
      r_raw_col   <= '0;
      r_raw_row   <= '0;
      r_pan_col   <= '0;
      r_pan_row   <= '0;
      r_shd_col   <= '0;
      r_shd_row   <= '0;
      r_pan_busy  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_map    <= 1'b0;
      r_world_col <= '0;
      r_world_row <= '0;
    end else begin
      r_sub_col   <= w_sub_col_nxt;
      r_sub_row   <= w_sub_row_nxt;
      r_raw_col   <= w_raw_col_nxt;
      r_raw_row   <= w_raw_row_nxt;
      if (w_frame_start && r_pan_busy) begin
        r_pan_col <= r_shd_col;
        r_pan_row <= r_shd_row;
      end
      // A load coincident with frame_start lands in the shadow and stays pending.
      if (pan_load) begin
        r_shd_col  <= pan_col_in;
        r_shd_row  <= pan_row_in;
        r_pan_busy <= 1'b1;
      end else if (w_frame_start) begin
        r_pan_busy <= 1'b0;
      end
      r_out_valid <= w_enable;
      r_in_map    <= w_in_map_nxt;
      r_world_col <= w_show ? w_raw_col_nxt[WORLD_COL_W-1:0] : '0;
      r_world_row <= w_show ? w_raw_row_nxt[WORLD_ROW_W-1:0] : '0;
    end
  end

  assign pan_busy     = r_pan_busy;
  assign world_row    = r_world_row;
  assign world_column = r_world_col;
  assign sub_row      = r_sub_row;
  assign sub_col      = r_sub_col;
  assign vid_addr     = {r_world_row, r_world_col};
  assign out_valid    = r_out_valid;
  assign in_map       = r_in_map;

endmodule

// File: tb/tb_vga_viewport_scaler.sv
// Directed bench for vga_viewport_scaler: one clamp-mode and one wrap-mode instance share stimulus.
module tb_vga_viewport_scaler;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pixel_row, pixel_column;
  logic        video_on, pan_load;
  logic [6:0]  pan_col_in, pan_row_in;

  logic        c_pan_busy, c_out_valid, c_in_map;
  logic [6:0]  c_world_row, c_world_column;
  logic [2:0]  c_sub_row, c_sub_col;
  logic [13:0] c_vid_addr;
  logic        w_pan_busy, w_out_valid, w_in_map;
  logic [6:0]  w_world_row, w_world_column;
  logic [2:0]  w_sub_row, w_sub_col;
  logic [13:0] w_vid_addr;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vga_viewport_scaler #(.WRAP_MODE(0)) u_clamp (
    .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .video_on(video_on), .pan_col_in(pan_col_in), .pan_row_in(pan_row_in), .pan_load(pan_load),
    .pan_busy(c_pan_busy), .world_row(c_world_row), .world_column(c_world_column),
    .sub_row(c_sub_row), .sub_col(c_sub_col), .vid_addr(c_vid_addr),
    .out_valid(c_out_valid), .in_map(c_in_map));

  vga_viewport_scaler #(.WRAP_MODE(1)) u_wrap (
    .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .video_on(video_on), .pan_col_in(pan_col_in), .pan_row_in(pan_row_in), .pan_load(pan_load),
    .pan_busy(w_pan_busy), .world_row(w_world_row), .world_column(w_world_column),
    .sub_row(w_sub_row), .sub_col(w_sub_col), .vid_addr(w_vid_addr),
    .out_valid(w_out_valid), .in_map(w_in_map));

  // Present one pixel, clock it in, and leave outputs settled 1ns after the edge.
  task automatic step(input int r, input int c, input bit v, input bit ld);
    pixel_row    = 12'(r);
    pixel_column = 12'(c);
    video_on     = v;
    pan_load     = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pan_col_in = 7'(i * 37 + 5);
      pan_row_in = 7'(i * 11 + 3);
      step(i * 7, i * 3 + 1, 1'b1, 1'b1);
      checks++;
      if ({c_out_valid, c_in_map, c_pan_busy, c_vid_addr, c_sub_row, c_sub_col} !== 21'd0)
        $display("FAIL reset_clamp cyc%0d got v%b m%b b%b a%0d sr%0d sc%0d want all 0", i,
                 c_out_valid, c_in_map, c_pan_busy, c_vid_addr, c_sub_row, c_sub_col);
      else passed++;
      checks++;
      if ({w_out_valid, w_in_map, w_pan_busy, w_vid_addr, w_sub_row, w_sub_col} !== 21'd0)
        $display("FAIL reset_wrap cyc%0d got v%b m%b b%b a%0d sr%0d sc%0d want all 0", i,
                 w_out_valid, w_in_map, w_pan_busy, w_vid_addr, w_sub_row, w_sub_col);
      else passed++;
    end
    reset = 1'b0;
    step(0, 0, 1'b0, 1'b0);
    checks++;
    if ({c_out_valid, c_in_map, c_pan_busy, c_vid_addr, c_sub_row, c_sub_col,
         w_out_valid, w_in_map, w_pan_busy, w_vid_addr, w_sub_row, w_sub_col} !== 42'd0)
      $display("FAIL reset_release got c_addr %0d w_addr %0d c_v%b w_v%b want all 0",
               c_vid_addr, w_vid_addr, c_out_valid, w_out_valid);
    else passed++;
  endtask

  task automatic test_default_scaling();
    for (int c = 0; c < 1024; c++) begin
      step(0, c, 1'b1, 1'b0);
      if (c == 5) begin
        checks++;
        if ({c_world_row, c_world_column, c_sub_col, c_out_valid, c_in_map} !== {7'd0, 7'd0, 3'd5, 2'b11})
          $display("FAIL scale_c5 got row %0d col %0d sub_col %0d v%b m%b want 0 0 5 1 1",
                   c_world_row, c_world_column, c_sub_col, c_out_valid, c_in_map);
        else passed++;
      end
      if (c == 6) begin
        checks++;
        if ({c_world_column, c_sub_col} !== {7'd1, 3'd0})
          $display("FAIL scale_c6 got col %0d sub_col %0d want 1 0", c_world_column, c_sub_col);
        else passed++;
      end
      if (c == 767) begin
        checks++;
        if ({c_world_column, c_in_map} !== {7'd127, 1'b1})
          $display("FAIL scale_c767_clamp got col %0d in_map %b want 127 1", c_world_column, c_in_map);
        else passed++;
      end
      if (c == 768) begin
        checks++;
        if ({c_in_map, c_out_valid, c_vid_addr} !== {1'b0, 1'b1, 14'd0})
          $display("FAIL scale_c768_clamp got in_map %b valid %b addr %0d want 0 1 0",
                   c_in_map, c_out_valid, c_vid_addr);
        else passed++;
        checks++;
        if ({w_world_column, w_in_map} !== {7'd0, 1'b1})
          $display("FAIL scale_c768_wrap got col %0d in_map %b want 0 1", w_world_column, w_in_map);
        else passed++;
      end
      if (c == 1023) begin
        checks++;
        if ({w_world_column, w_sub_col, c_in_map} !== {7'd42, 3'd3, 1'b0})
          $display("FAIL scale_c1023 got wrap col %0d sub_col %0d clamp in_map %b want 42 3 0",
                   w_world_column, w_sub_col, c_in_map);
        else passed++;
      end
    end
    step(0, 0, 1'b0, 1'b0);
    for (int r = 1; r <= 6; r++) begin
      for (int c = 0; c < 8; c++) begin
        step(r, c, 1'b1, 1'b0);
        if (c == 0 && r == 5) begin
          checks++;
          if ({c_world_row, c_sub_row} !== {7'd0, 3'd5})
            $display("FAIL scale_r5 got row %0d sub_row %0d want 0 5", c_world_row, c_sub_row);
          else passed++;
        end
        if (c == 0 && r == 6) begin
          checks++;
          if ({c_world_row, c_sub_row, w_world_row, w_sub_row} !== {7'd1, 3'd0, 7'd1, 3'd0})
            $display("FAIL scale_r6 got c row %0d sr %0d w row %0d sr %0d want 1 0 1 0",
                     c_world_row, c_sub_row, w_world_row, w_sub_row);
          else passed++;
        end
      end
      step(r, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_pan_timing();
    for (int c = 0; c < 8; c++) step(0, c, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    pan_col_in = 7'd10;
    pan_row_in = 7'd5;
    for (int c = 0; c < 64; c++) begin
      step(300, c, 1'b1, (c == 40));
      if (c == 39) begin
        checks++;
        if (c_pan_busy !== 1'b0) $display("FAIL pan_busy_before got %b want 0", c_pan_busy);
        else passed++;
      end
      if (c == 40) begin
        checks++;
        if ({c_pan_busy, w_pan_busy} !== 2'b11)
          $display("FAIL pan_busy_rise got %b%b want 11", c_pan_busy, w_pan_busy);
        else passed++;
      end
      if (c == 41) begin
        checks++;
        if ({c_world_row, c_world_column, c_sub_row} !== {7'd0, 7'd6, 3'd1})
          $display("FAIL pan_same_frame got row %0d col %0d sub_row %0d want 0 6 1",
                   c_world_row, c_world_column, c_sub_row);
        else passed++;
      end
    end
    step(0, 0, 1'b0, 1'b0);
    checks++;
    if (w_pan_busy !== 1'b1) $display("FAIL pan_busy_hold got %b want 1", w_pan_busy);
    else passed++;
    for (int c = 0; c < 7; c++) begin
      step(0, c, 1'b1, 1'b0);
      if (c == 0) begin
        checks++;
        if ({c_vid_addr, w_vid_addr, c_in_map} !== {14'd650, 14'd650, 1'b1})
          $display("FAIL pan_applied got c_addr %0d w_addr %0d in_map %b want 650 650 1",
                   c_vid_addr, w_vid_addr, c_in_map);
        else passed++;
        checks++;
        if ({c_pan_busy, w_pan_busy} !== 2'b00)
          $display("FAIL pan_busy_fall got %b%b want 00", c_pan_busy, w_pan_busy);
        else passed++;
      end
      if (c == 6) begin
        checks++;
        if (c_world_column !== 7'd11) $display("FAIL pan_c6 got %0d want 11", c_world_column);
        else passed++;
      end
    end
    step(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_coincident_load();
    pan_col_in = 7'd100;
    pan_row_in = 7'd0;
    step(0, 0, 1'b1, 1'b1);
    checks++;
    if ({c_vid_addr, c_pan_busy} !== {14'd650, 1'b1})
      $display("FAIL coincident_old_pan got addr %0d busy %b want 650 1", c_vid_addr, c_pan_busy);
    else passed++;
    for (int c = 1; c < 6; c++) step(0, c, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_map_edges();
    for (int c = 0; c <= 200; c++) begin
      step(0, c, 1'b1, 1'b0);
      if (c == 0) begin
        checks++;
        if ({c_world_row, c_world_column, c_pan_busy} !== {7'd0, 7'd100, 1'b0})
          $display("FAIL edge_new_pan got row %0d col %0d busy %b want 0 100 0",
                   c_world_row, c_world_column, c_pan_busy);
        else passed++;
      end
      if (c == 167) begin
        checks++;
        if ({c_world_column, c_in_map, w_world_column, w_in_map} !== {7'd127, 1'b1, 7'd127, 1'b1})
          $display("FAIL edge_c167 got c %0d/%b w %0d/%b want 127/1 127/1",
                   c_world_column, c_in_map, w_world_column, w_in_map);
        else passed++;
      end
      if (c == 168) begin
        checks++;
        if ({c_in_map, c_vid_addr, c_out_valid} !== {1'b0, 14'd0, 1'b1})
          $display("FAIL edge_c168_clamp got in_map %b addr %0d valid %b want 0 0 1",
                   c_in_map, c_vid_addr, c_out_valid);
        else passed++;
        checks++;
        if ({w_world_column, w_in_map} !== {7'd0, 1'b1})
          $display("FAIL edge_c168_wrap got col %0d in_map %b want 0 1", w_world_column, w_in_map);
        else passed++;
      end
      if (c == 174) begin
        checks++;
        if (w_world_column !== 7'd1) $display("FAIL edge_c174_wrap got %0d want 1", w_world_column);
        else passed++;
      end
    end
    step(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_video_gap();
    for (int c = 0; c < 30; c++) step(1, c, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1, 30, 1'b0, 1'b0);
      checks++;
      if ({c_out_valid, c_in_map, w_out_valid, w_in_map} !== 4'b0000)
        $display("FAIL gap_qual cyc%0d got %b%b%b%b want 0000", i,
                 c_out_valid, c_in_map, w_out_valid, w_in_map);
      else passed++;
    end
    checks++;
    if ({w_world_column, w_sub_col, c_sub_col} !== {7'd104, 3'd5, 3'd5})
      $display("FAIL gap_hold got col %0d w_sc %0d c_sc %0d want 104 5 5",
               w_world_column, w_sub_col, c_sub_col);
    else passed++;
    step(1, 30, 1'b1, 1'b0);
    checks++;
    if ({c_world_column, w_world_column, c_sub_col, c_sub_row, c_out_valid} !==
        {7'd105, 7'd105, 3'd0, 3'd1, 1'b1})
      $display("FAIL gap_resume got c %0d w %0d sc %0d sr %0d v %b want 105 105 0 1 1",
               c_world_column, w_world_column, c_sub_col, c_sub_row, c_out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_line();
    for (int c = 31; c <= 40; c++) step(1, c, 1'b1, 1'b0);
    reset = 1'b1;
    pan_col_in = 7'd55;
    pan_row_in = 7'd9;
    step(1, 41, 1'b1, 1'b1);
    checks++;
    if ({c_out_valid, c_in_map, c_pan_busy, c_vid_addr, c_sub_col,
         w_out_valid, w_in_map, w_pan_busy, w_vid_addr, w_sub_col} !== 36'd0)
      $display("FAIL midreset got c_addr %0d w_addr %0d c_v%b w_v%b c_b%b want all 0",
               c_vid_addr, w_vid_addr, c_out_valid, w_out_valid, c_pan_busy);
    else passed++;
    reset = 1'b0;
    for (int c = 42; c < 60; c++) step(1, c, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    for (int c = 0; c < 14; c++) begin
      step(0, c, 1'b1, 1'b0);
      if (c == 0) begin
        checks++;
        if ({c_vid_addr, c_in_map, c_pan_busy} !== {14'd0, 1'b1, 1'b0})
          $display("FAIL postreset_c0 got addr %0d in_map %b busy %b want 0 1 0",
                   c_vid_addr, c_in_map, c_pan_busy);
        else passed++;
      end
      if (c == 13) begin
        checks++;
        if ({c_world_column, c_sub_col, w_world_column} !== {7'd2, 3'd1, 7'd2})
          $display("FAIL postreset_c13 got c %0d sc %0d w %0d want 2 1 2",
                   c_world_column, c_sub_col, w_world_column);
        else passed++;
      end
    end
    step(0, 0, 1'b0, 1'b0);
    step(1, 0, 1'b1, 1'b0);
    checks++;
    if ({c_sub_row, c_world_row} !== {3'd1, 7'd0})
      $display("FAIL postreset_row1 got sr %0d row %0d want 1 0", c_sub_row, c_world_row);
    else passed++;
  endtask

  initial begin
    reset        = 1'b1;
    pixel_row    = '0;
    pixel_column = '0;
    video_on     = 1'b0;
    pan_load     = 1'b0;
    pan_col_in   = '0;
    pan_row_in   = '0;
    test_reset();
    test_default_scaling();
    test_pan_timing();
    test_coincident_load();
    test_map_edges();
    test_video_gap();
    test_reset_mid_line();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
